fp_mul_arbiter: RTL

- Shares one combinational single-precision FP multiplier (fp_X/fp_Y/r_mode -> fp_Z/ovrf/udrf) between NREQ requesters.
- Each requester uses a valid/ready port. A round-robin arbiter grants one request per cycle and registers the operands into an issue stage that drives the multiplier.
- Results are captured, tagged with the requester index and queued in a result FIFO with a valid/ready output.
- Sits between the ALU issue logic and the mul datapath.

---
 rtl/fp_mul_arb_pkg.sv | 30 +++
 rtl/fp_mul_res_fifo.sv | 63 ++++++
 rtl/fp_mul_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arb_pkg.sv
// Shared types for the FP multiplier arbiter: fp32 layout, rounding modes and
// the tagged result entry held in the result FIFO.
// No ports; imported by fp_mul_res_fifo and fp_mul_arbiter.
package fp_mul_arb_pkg;

    // Widest requester tag the arbiter supports (NREQ up to 8).
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    typedef struct packed {
        fp32_t              z;
        logic               ovrf;
        logic               udrf;
        logic [MAX_IDW-1:0] id;
    } res_entry_t;

endpackage

// File: rtl/fp_mul_res_fifo.sv
// Synchronous result FIFO of tagged multiplier results.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller's credit check keeps pushes off a full FIFO.
// Ports: clk/rst, i_push + i_push_dat, i_pop, o_head_dat, o_count, o_full, o_empty.
module fp_mul_res_fifo
    import fp_mul_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  res_entry_t   i_push_dat,
    input  logic         i_pop,
    output res_entry_t   o_head_dat,
    output logic [AW:0]  o_count,
    output logic         o_full,
    output logic         o_empty
);

    res_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_last_ptr;
    logic          w_pop;

    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign w_pop      = i_pop && !o_empty;
    assign w_last_ptr = r_rd_ptr - 1'b1;

    // When empty, keep showing the entry most recently popped; it stays intact
    // because the next push lands on r_rd_ptr, not on the slot behind it.
    assign o_head_dat = o_empty ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin share of one combinational fp32 multiplier among NREQ requesters.
// Latency: accept at t -> result at FIFO head (out_valid) at t+2.
// Backpressure: credit-based; req_ready drops when FIFO entries + issue slot reach FIFO_DEPTH.
// Ports: req_* (valid/ready requests), mul_* (to/from multiplier), out_* (valid/ready results).
// Optional: define FP_MUL_ARB_STICKY_EXC_EN to add exc_clr/exc_sticky per-requester
// sticky {ovrf,udrf} flags, set on pop and cleared (with priority) by exc_clr.
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_x,
    input  logic [NREQ*32-1:0] req_y,
    input  logic [NREQ*3-1:0]  req_rmode,
    output logic [31:0]        mul_x,
    output logic [31:0]        mul_y,
    output logic [2:0]         mul_rmode,
    input  logic [31:0]        mul_z,
    input  logic               mul_ovrf,
    input  logic               mul_udrf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_z,
    output logic               out_ovrf,
    output logic               out_udrf,
`ifdef FP_MUL_ARB_STICKY_EXC_EN
    input  logic [NREQ-1:0]    exc_clr,
    output logic [2*NREQ-1:0]  exc_sticky,
`endif
    output logic [IDW-1:0]     out_id
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_credit;
    logic           w_gnt_vld;
    logic [IDW-1:0] w_gnt_idx;
    logic [31:0]    w_sel_x;
    logic [31:0]    w_sel_y;
    logic [2:0]     w_sel_rmode;
    res_entry_t     w_push_dat;
    res_entry_t     w_head;

    logic           r_iss_vld;
    logic [31:0]    r_iss_x;
    logic [31:0]    r_iss_y;
    rmode_e         r_iss_rmode;
    logic [IDW-1:0] r_iss_id;
    logic [IDW-1:0] r_rr_ptr;

    // The in-flight issue slot reserves a FIFO entry, so the multiplier result
    // always has somewhere to go regardless of out_ready.
    assign w_credit = !w_full && ((w_count + CW'(r_iss_vld)) < CW'(FIFO_DEPTH));

    // Round robin: pick the valid requester closest to r_rr_ptr going upward.
    always_comb begin : arb
        int best;
        best        = NREQ;
        w_gnt_idx   = '0;
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_rmode = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (req_valid[j] && (((j + NREQ - int'(r_rr_ptr)) % NREQ) < best)) begin
                best        = (j + NREQ - int'(r_rr_ptr)) % NREQ;
                w_gnt_idx   = IDW'(j);
                w_sel_x     = req_x[32*j +: 32];
                w_sel_y     = req_y[32*j +: 32];
                w_sel_rmode = req_rmode[3*j +: 3];
            end
        end
        w_gnt_vld = w_credit && (best < NREQ);
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = w_gnt_vld && (w_gnt_idx == IDW'(j));
        end
    end

    // Issue stage: operands held here drive the multiplier for one cycle;
    // they keep their last values while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_vld   <= 1'b0;
            r_iss_x     <= '0;
            r_iss_y     <= '0;
            r_iss_rmode <= RNE;
            r_iss_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_iss_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_iss_x     <= w_sel_x;
                r_iss_y     <= w_sel_y;
                r_iss_rmode <= rmode_e'(w_sel_rmode);
                r_iss_id    <= w_gnt_idx;
                r_rr_ptr    <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign mul_x     = r_iss_x;
    assign mul_y     = r_iss_y;
    assign mul_rmode = r_iss_rmode;

    always_comb begin
        w_push_dat      = '0;
        w_push_dat.z    = fp32_t'(mul_z);
        w_push_dat.ovrf = mul_ovrf;
        w_push_dat.udrf = mul_udrf;
        w_push_dat.id   = MAX_IDW'(r_iss_id);
    end

    assign w_pop = !w_empty && out_ready;

    fp_mul_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_iss_vld),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_z     = w_head.z;
    assign out_ovrf  = w_head.ovrf;
    assign out_udrf  = w_head.udrf;
    assign out_id    = IDW'(w_head.id);

`ifdef FP_MUL_ARB_STICKY_EXC_EN
    logic [2*NREQ-1:0] r_exc_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc_sticky <= '0;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (exc_clr[j]) begin
                    r_exc_sticky[2*j +: 2] <= 2'b00;
                end else if (w_pop && (w_head.id == MAX_IDW'(j))) begin
                    r_exc_sticky[2*j +: 2] <= r_exc_sticky[2*j +: 2] | {w_head.ovrf, w_head.udrf};
                end
            end
        end
    end

    assign exc_sticky = r_exc_sticky;
`endif

endmodule
